// File: rtl/bus_alu_sequencer_if.sv
// Request/load handshake bundle for bus_alu_sequencer.
// master drives requests and loads; slave returns ready, done and err.
interface bus_alu_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    parameter int OPW   = 5
) ();
    localparam int AW = $clog2(NREGS);

    logic             req_valid;
    logic             req_ready;
    logic [OPW-1:0]   req_op;
    logic [AW-1:0]    req_ra;
    logic [AW-1:0]    req_rb;
    logic [AW-1:0]    req_rd;
    logic             ld_valid;
    logic             ld_ready;
    logic [AW-1:0]    ld_rd;
    logic [WIDTH-1:0] ld_data;
    logic             done;
    logic             err;

    modport master (
        output req_valid, req_op, req_ra, req_rb, req_rd,
        output ld_valid, ld_rd, ld_data,
        input  req_ready, ld_ready, done, err
    );

    modport slave (
        input  req_valid, req_op, req_ra, req_rb, req_rd,
        input  ld_valid, ld_rd, ld_data,
        output req_ready, ld_ready, done, err
    );
endinterface

// File: rtl/bus_alu_sequencer.sv
// Single-bus register file + ALU sequencer: IDLE -> TY -> TZ -> TWB.
// Ports: clk, clr (async active-low), bus (request/load handshake,
// done/err), hi, lo, bus_dbg, rd_sel/rd_data (combinational read).
// Option: BUSDP_R0_ZERO_EN makes R0 read as zero and ignore writes.
module bus_alu_sequencer #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    parameter int OPW   = 5
) (
    input  logic                       clk,
    input  logic                       clr,
    bus_alu_sequencer_if.slave         bus,
    output logic [WIDTH-1:0]           hi,
    output logic [WIDTH-1:0]           lo,
    output logic [WIDTH-1:0]           bus_dbg,
    input  logic [$clog2(NREGS)-1:0]   rd_sel,
    output logic [WIDTH-1:0]           rd_data
);
    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, TY, TZ, TWB} state_t;

    state_t           state;
    state_t           state_nx;

    logic [WIDTH-1:0] rf    [NREGS];
    logic [WIDTH-1:0] rf_rd [NREGS];

    logic [OPW-1:0]   op_q;
    logic [AW-1:0]    ra_q;
    logic [AW-1:0]    rb_q;
    logic [AW-1:0]    rd_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] zhi_q;
    logic [WIDTH-1:0] zlo_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;
    logic             err_q;

    logic             ld_rdy;
    logic             req_rdy;
    logic             ld_go;
    logic             req_go;
    logic             wb_reg;
    logic             wb_mul;
    logic             wb_bad;
    logic             illegal;
    logic             ld_wr_ok;
    logic             wb_wr_ok;
    logic [WIDTH-1:0] bus_v;
    logic [WIDTH-1:0] alu_hi;
    logic [WIDTH-1:0] alu_lo;
    logic [2*WIDTH-1:0] prod;

    // Read view of the register file; R0 may be forced to zero.
    always_comb begin
        for (int i = 0; i < NREGS; i++) rf_rd[i] = rf[i];
`ifdef BUSDP_R0_ZERO_EN
        rf_rd[0] = '0;
`endif
    end

`ifdef BUSDP_R0_ZERO_EN
    assign ld_wr_ok = (bus.ld_rd != '0);
    assign wb_wr_ok = (rd_q != '0);
`else
    assign ld_wr_ok = 1'b1;
    assign wb_wr_ok = 1'b1;
`endif

    assign illegal = (op_q > OPW'(7));

    // State register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (req_go) state_nx = TY;
            TY:   state_nx = TZ;
            TZ:   state_nx = TWB;
            TWB:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output / bus-step decode
    always_comb begin
        ld_rdy  = 1'b0;
        req_rdy = 1'b0;
        ld_go   = 1'b0;
        req_go  = 1'b0;
        wb_reg  = 1'b0;
        wb_mul  = 1'b0;
        wb_bad  = 1'b0;
        bus_v   = rf_rd[rd_sel];
        unique case (state)
            IDLE: begin
                // Ready is held low while reset is asserted.
                ld_rdy  = clr;
                req_rdy = clr & ~bus.ld_valid;
                ld_go   = bus.ld_valid & ld_rdy;
                req_go  = bus.req_valid & req_rdy;
            end
            TY:  bus_v = rf_rd[ra_q];
            TZ:  bus_v = rf_rd[rb_q];
            TWB: begin
                bus_v  = zlo_q;
                wb_bad = illegal;
                wb_mul = ~illegal & (op_q == OPW'(6));
                wb_reg = ~illegal & (op_q != OPW'(6));
            end
            default: ;
        endcase
    end

    // ALU: Y is operand A, the bus carries operand B during TZ.
    assign prod = {{WIDTH{1'b0}}, y_q} * {{WIDTH{1'b0}}, bus_v};

    always_comb begin
        alu_hi = '0;
        alu_lo = '0;
        case (op_q[2:0])
            3'd0: alu_lo = y_q + bus_v;
            3'd1: alu_lo = y_q - bus_v;
            3'd2: alu_lo = y_q & bus_v;
            3'd3: alu_lo = y_q | bus_v;
            3'd4: alu_lo = y_q << bus_v[SW-1:0];
            3'd5: alu_lo = y_q >> bus_v[SW-1:0];
            3'd6: {alu_hi, alu_lo} = prod;
            3'd7: alu_lo = ~y_q;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
            op_q   <= '0;
            ra_q   <= '0;
            rb_q   <= '0;
            rd_q   <= '0;
            y_q    <= '0;
            zhi_q  <= '0;
            zlo_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= (state == TWB);
            err_q  <= wb_bad;
            if (req_go) begin
                op_q <= bus.req_op;
                ra_q <= bus.req_ra;
                rb_q <= bus.req_rb;
                rd_q <= bus.req_rd;
            end
            if (state == TY) y_q <= bus_v;
            if (state == TZ) begin
                zhi_q <= alu_hi;
                zlo_q <= alu_lo;
            end
            // Loads happen only in IDLE, write-back only in TWB.
            if (ld_go && ld_wr_ok) rf[bus.ld_rd] <= bus.ld_data;
            if (wb_reg && wb_wr_ok) rf[rd_q] <= zlo_q;
            if (wb_mul) begin
                hi_q <= zhi_q;
                lo_q <= zlo_q;
            end
        end
    end

    assign bus.ld_ready  = ld_rdy;
    assign bus.req_ready = req_rdy;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign hi            = hi_q;
    assign lo            = lo_q;
    assign bus_dbg       = bus_v;
    assign rd_data       = rf_rd[rd_sel];
endmodule

// File: doc/bus_alu_sequencer.md
# bus_alu_sequencer

Parametrised register-file-plus-bus execution unit for the single-bus processor datapath. It holds NREGS general registers, the Y, Z (hi/lo), HI and LO registers and one shared internal bus, and executes one three-operand ALU request at a time by sequencing the classic Y-load / Z-compute / write-back bus steps itself. It replaces per-cycle external out/in strobes with a valid/ready request port, plus a direct register-load port for memory data.

## Interface

Parameters:
- WIDTH, 32, bus and register width
- NREGS, 16, number of general registers (power of two, ≥2); AW = clog2(NREGS)
- OPW, 5, opcode field width

Ports:
- Clocking: one clock; reset is asynchronous and active-low (clk, clr).
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous active-low reset
- req_valid  in  1  ALU request present
- req_ready  out  1  request accepted when valid&ready at rising edge
- req_op  in  OPW  operation code
- req_ra / req_rb / req_rd  in  AW each  operand A, operand B, destination register
- ld_valid  in  1  direct register load request
- ld_ready  out  1  load accepted when valid&ready
- ld_rd  in  AW  load destination
- ld_data  in  WIDTH  load value
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done: illegal opcode, nothing written
- hi, lo  out  WIDTH  HI/LO register contents
- bus_dbg  out  WIDTH  current internal bus value
- rd_sel  in  AW, rd_data  out  WIDTH  combinational register read port

## Operation

- States: IDLE, TY, TZ, TWB.
- IDLE: ld_ready = 1; req_ready = !ld_valid. Load and request both valid: load wins, request stalls.
- Load accepted: R[ld_rd] <= ld_data at that edge; stays IDLE; no done.
- Request accepted: op, ra, rb, rd latched; -> TY.
- TY: bus = R[ra]; Y <= bus; -> TZ.
- TZ: bus = R[rb]; {Zhi, Zlo} <= ALU(Y, bus); -> TWB.
- TWB: bus = Zlo; write-back (below); -> IDLE.
- Ops (Zhi = 0 unless stated): 0 ADD a+b mod 2^WIDTH; 1 SUB a-b mod 2^WIDTH; 2 AND; 3 OR; 4 SHL a<<b[clog2(WIDTH)-1:0]; 5 SHR logical, same amount; 6 MUL unsigned, {Zhi,Zlo} = full 2*WIDTH product; 7 NOT a (b ignored, still driven).
- Write-back: ops 0-5, 7 -> R[rd] <= Zlo. Op 6 -> HI <= Zhi, LO <= Zlo; R[rd] unchanged.
- Ops ≥8: no register, HI or LO written; done and err both pulse.
- ra, rb, rd may alias; operands are the values at TY/TZ.
- IDLE bus = R[rd_sel].

## Timing

- Reset (clr low, any state): all registers, Y, Z, HI, LO = 0; state IDLE; done = err = 0; req_ready = ld_ready = 0 while clr low.
- Reset mid-operation aborts: no write-back, no done.
- Request accepted at edge E0 -> TY in the cycle after E0. Y is captured at E1, Z at E2, and write-back happens at E3.
- done/err are registered and high for exactly the one cycle following E3. The state is IDLE in that same cycle, so the next request can be accepted at E4: 4 cycles per op.
- Result is visible on rd_data the cycle after E3. No hazard between back-to-back requests.
- req_* inputs are ignored outside IDLE.

## Configuration

- BUSDP_R0_ZERO_EN defined: R0 reads as 0 on the bus and on rd_data. Writes to R0 (load or write-back) are discarded, but done still pulses.
- Not defined: R0 is an ordinary register.

## Test plan

- Load R1=7, R2=5; ADD ra=1 rb=2 rd=3 -> done 4 cycles after acceptance, err=0, R3=12.
- SUB ra=2 rb=1 rd=4 with R1=7, R2=5 -> R4=0xFFFFFFFE. SHL R5=1 by R6=31 -> 0x80000000.
- MUL with R1=0x80000000, R2=4, rd=7 -> HI=0x00000002, LO=0x00000000, R7 unchanged.
- Op 9 -> done=err=1 for one cycle; all registers, HI, LO unchanged. ld_valid and req_valid together in IDLE -> load taken, req_ready=0, request accepted next cycle.
- ADD in progress, clr pulsed low during TZ -> every register 0, no done; the request is not resumed after reset release.
- With BUSDP_R0_ZERO_EN: load R0=0xDEAD, then ADD ra=0 rb=1 rd=2 with R1=3 -> R2=3, rd_data(sel 0)=0. Without the macro: R2=0xDEB0.
